// File: rtl/phase_loader_pkg.sv
// Shared types and sizing helpers for the phase-memory loader.
// Default geometry matches the Gaussian systematization datapath.
package phase_loader_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_M = 2;
  localparam int DEF_L = 8;
  localparam int DEF_K = 16;

  localparam int ELEM_W = $clog2(DEF_M);
  localparam int WORDS  = DEF_L * DEF_K / DEF_N;
  localparam int BLOCKS = DEF_K / DEF_N;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_KICK = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  // Lowest bit of element slot j inside a packed word of ew-bit elements.
  function automatic int slot_lsb(input int j, input int ew);
    return j * ew;
  endfunction

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_loader_elem_packer.sv
// Serial-in / N-wide-out element packer: one element per accepted beat,
// a registered word pulse one cycle after the beat that fills slot N-1.
module elem_packer
  import phase_loader_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int EW = ELEM_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            beat_vld_i,
  input  logic [EW-1:0]   beat_dat_i,
  output logic            elem_last_o,
  output logic            word_vld_o,
  output logic [N*EW-1:0] word_dat_o
);

  localparam int CW = cnt_w(N);

  logic [CW-1:0]   elem_cnt_q;
  logic [N*EW-1:0] pack_q;
  logic [N*EW-1:0] pack_d;
  logic [N*EW-1:0] word_q;
  logic            word_vld_q;

  assign elem_last_o = (elem_cnt_q == CW'(N - 1));
  assign word_vld_o  = word_vld_q;
  assign word_dat_o  = word_q;

  always_comb begin
    pack_d = pack_q;
    for (int j = 0; j < N; j++) begin
      if (elem_cnt_q == CW'(j)) begin
        pack_d[slot_lsb(j, EW) +: EW] = beat_dat_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elem_cnt_q <= '0;
      pack_q     <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      word_vld_q <= 1'b0;
      if (clr_i) begin
        elem_cnt_q <= '0;
        pack_q     <= '0;
      end else if (beat_vld_i) begin
        if (elem_last_o) begin
          // Word complete: hand it out and start the next one from empty.
          elem_cnt_q <= '0;
          pack_q     <= '0;
          word_q     <= pack_d;
          word_vld_q <= 1'b1;
        end else begin
          elem_cnt_q <= elem_cnt_q + CW'(1);
          pack_q     <= pack_d;
        end
      end
    end
  end

endmodule

// File: rtl/phase_loader.sv
// Streams an L x K matrix into phase memory, kicks the phase engine and
// reports done/fail; one load-and-run transaction per accepted go pulse.
module phase_loader
  import phase_loader_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M,
  parameter int L = DEF_L,
  parameter int K = DEF_K,
  localparam int EW   = $clog2(M),
  localparam int WRDS = L * K / N,
  localparam int BW   = $clog2(K / N + 1),
  localparam int AW   = cnt_w(WRDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [BW-1:0]   cfg_start_block,
  input  logic            cfg_last_phase,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [EW-1:0]   in_data,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [N*EW-1:0] data_in,
  output logic            ph_start,
  output logic [BW-1:0]   ph_start_block,
  output logic            ph_last_phase,
  input  logic            ph_done,
  input  logic            ph_fail,
  output logic            busy,
  output logic            done,
  output logic            fail
);

  localparam int WC_W = $clog2(WRDS + 1);

  state_e          state_q;
  logic            in_ready_q;
  logic [WC_W-1:0] word_cnt_q;
  logic [AW-1:0]   wr_addr_q;
  logic            ph_start_q;
  logic [BW-1:0]   start_block_q;
  logic            last_phase_q;
  logic            done_q;
  logic            fail_q;

  logic beat_acc;
  logic elem_last;
  logic pack_clr;
  logic final_beat;

  assign beat_acc   = in_valid && in_ready_q;
  assign pack_clr   = (state_q == S_IDLE) && go;
  assign final_beat = beat_acc && elem_last && (word_cnt_q == WC_W'(WRDS - 1));

  elem_packer #(
    .N  (N),
    .EW (EW)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (pack_clr),
    .beat_vld_i  (beat_acc),
    .beat_dat_i  (in_data),
    .elem_last_o (elem_last),
    .word_vld_o  (wr_en),
    .word_dat_o  (data_in)
  );

  assign in_ready       = in_ready_q;
  assign wr_addr        = wr_addr_q;
  assign ph_start       = ph_start_q;
  assign ph_start_block = start_block_q;
  assign ph_last_phase  = last_phase_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign fail           = fail_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b0;
      word_cnt_q    <= '0;
      wr_addr_q     <= '0;
      ph_start_q    <= 1'b0;
      start_block_q <= '0;
      last_phase_q  <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      ph_start_q <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b0;
          if (go) begin
            start_block_q <= cfg_start_block;
            last_phase_q  <= cfg_last_phase;
            word_cnt_q    <= '0;
            state_q       <= S_LOAD;
          end
        end
        S_LOAD: begin
          // word_cnt reaching WRDS means the final write is on the bus now.
          if (word_cnt_q == WC_W'(WRDS)) begin
            in_ready_q <= 1'b0;
            ph_start_q <= 1'b1;
            state_q    <= S_KICK;
          end else begin
            in_ready_q <= !final_beat;
            if (beat_acc && elem_last) begin
              wr_addr_q  <= word_cnt_q[AW-1:0];
              word_cnt_q <= word_cnt_q + WC_W'(1);
            end
          end
        end
        S_KICK: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (ph_fail) begin
            fail_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (ph_done) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_loader.sv
// Directed bench for phase_loader at N=4 M=2 L=8 K=16.
module tb_phase_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [2:0] cfg_start_block;
  logic       cfg_last_phase;
  logic       in_valid;
  logic       in_ready;
  logic [0:0] in_data;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [3:0] data_in;
  logic       ph_start;
  logic [2:0] ph_start_block;
  logic       ph_last_phase;
  logic       ph_done;
  logic       ph_fail;
  logic       busy;
  logic       done;
  logic       fail;

  int checks = 0;
  int errors = 0;

  int acc_cnt, wr_cnt, start_cnt, done_cnt, fail_cnt;
  int cyc = 0;
  int go_cyc = 0;
  int start_cyc = 0;
  bit busy_prev = 1'b0;
  logic [4:0] wa [64];
  logic [3:0] wd [64];
  int         wc [64];

  always #5 clk = ~clk;

  phase_loader dut (
    .clk             (clk),
    .rst             (rst),
    .go              (go),
    .cfg_start_block (cfg_start_block),
    .cfg_last_phase  (cfg_last_phase),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .data_in         (data_in),
    .ph_start        (ph_start),
    .ph_start_block  (ph_start_block),
    .ph_last_phase   (ph_last_phase),
    .ph_done         (ph_done),
    .ph_fail         (ph_fail),
    .busy            (busy),
    .done            (done),
    .fail            (fail)
  );

  // Passive recorder sampled on the falling edge, where inputs and outputs are stable.
  always @(negedge clk) begin
    cyc++;
    if (in_valid && in_ready) acc_cnt++;
    if (wr_en) begin
      if (wr_cnt < 64) begin
        wa[wr_cnt] = wr_addr;
        wd[wr_cnt] = data_in;
        wc[wr_cnt] = cyc;
      end
      wr_cnt++;
    end
    if (ph_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (done) done_cnt++;
    if (fail) fail_cnt++;
    if (busy && !busy_prev) go_cyc = cyc;
    busy_prev = busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon;
    acc_cnt = 0; wr_cnt = 0; start_cnt = 0; done_cnt = 0; fail_cnt = 0;
  endtask

  task automatic pulse_go(input logic [2:0] sb, input logic lp);
    tick;
    go = 1'b1; cfg_start_block = sb; cfg_last_phase = lp;
    tick;
    go = 1'b0; cfg_start_block = 3'd5; cfg_last_phase = ~lp;
  endtask

  // Feeds beats until `stop` are accepted; pat=0 gives element i = i&1, pat=1 all ones.
  task automatic drive_beats(input int ncyc, input bit thr, input bit pat, input int stop);
    for (int c = 0; c < ncyc; c++) begin
      tick;
      if (acc_cnt >= stop) in_valid = 1'b0;
      else begin
        in_valid = thr ? ~in_valid : 1'b1;
        in_data  = pat ? 1'b1 : 1'(acc_cnt & 1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    @(negedge clk);
    checks++;
    if ({in_ready, wr_en, ph_start, busy, done, fail} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b expected 000000", {in_ready, wr_en, ph_start, busy, done, fail});
    end
    checks++;
    if ({wr_addr, data_in, ph_start_block, ph_last_phase} !== 13'b0) begin
      errors++;
      $display("FAIL reset_values got %h expected 0", {wr_addr, data_in, ph_start_block, ph_last_phase});
    end
    tick;
    rst = 1'b0;
  endtask

  task automatic test_full_load;
    clear_mon;
    pulse_go(3'd0, 1'b0);
    drive_beats(140, 1'b0, 1'b0, 100000);
    checks++;
    if (acc_cnt !== 128) begin errors++; $display("FAIL full_beats got %0d expected 128", acc_cnt); end
    checks++;
    if (wr_cnt !== 32) begin errors++; $display("FAIL full_writes got %0d expected 32", wr_cnt); end
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (wa[k] !== 5'(k)) begin errors++; $display("FAIL full_addr[%0d] got %0d expected %0d", k, wa[k], k); end
      checks++;
      if (wd[k] !== 4'b1010) begin errors++; $display("FAIL full_data[%0d] got %b expected 1010", k, wd[k]); end
      checks++;
      if (wc[k] !== go_cyc + 5 + 4 * k) begin
        errors++; $display("FAIL full_wr_cycle[%0d] got %0d expected %0d", k, wc[k] - go_cyc, 5 + 4 * k);
      end
    end
    checks++;
    if (start_cnt !== 1) begin errors++; $display("FAIL full_start_count got %0d expected 1", start_cnt); end
    checks++;
    if (start_cyc !== go_cyc + 130) begin
      errors++; $display("FAIL full_start_cycle got %0d expected 130", start_cyc - go_cyc);
    end
    @(negedge clk);
    checks++;
    if ({busy, in_ready, ph_start} !== 3'b100) begin
      errors++; $display("FAIL full_run_state got %b expected 100", {busy, in_ready, ph_start});
    end
    tick;
    ph_done = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL full_done_early got %b expected 0", done); end
    tick;
    ph_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b10) begin errors++; $display("FAIL full_done_pulse got %b expected 10", {done, busy}); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL full_done_width got %b expected 0", done); end
    checks++;
    if (wr_cnt !== 32) begin errors++; $display("FAIL full_no_late_write got %0d expected 32", wr_cnt); end
  endtask

  task automatic test_throttled;
    clear_mon;
    pulse_go(3'd1, 1'b0);
    drive_beats(270, 1'b1, 1'b0, 100000);
    checks++;
    if (acc_cnt !== 128) begin errors++; $display("FAIL thr_beats got %0d expected 128", acc_cnt); end
    checks++;
    if (wr_cnt !== 32) begin errors++; $display("FAIL thr_writes got %0d expected 32", wr_cnt); end
    for (int k = 0; k < 32; k++) begin
      checks++;
      if ({wa[k], wd[k]} !== {5'(k), 4'b1010}) begin
        errors++; $display("FAIL thr_word[%0d] got %0d/%b expected %0d/1010", k, wa[k], wd[k], k);
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL thr_ready_low got %b expected 0", in_ready); end
    checks++;
    if (start_cnt !== 1 || start_cyc !== wc[31] + 1) begin
      errors++; $display("FAIL thr_start got cnt %0d delay %0d expected cnt 1 delay 1", start_cnt, start_cyc - wc[31]);
    end
    tick; ph_done = 1'b1;
    tick; ph_done = 1'b0;
    tick;
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL thr_done got cnt %0d busy %b expected cnt 1 busy 0", done_cnt, busy);
    end
  endtask

  task automatic test_fail;
    clear_mon;
    pulse_go(3'd0, 1'b0);
    drive_beats(140, 1'b0, 1'b0, 100000);
    checks++;
    if (start_cnt !== 1) begin errors++; $display("FAIL fail_start got %0d expected 1", start_cnt); end
    tick;
    ph_fail = 1'b1; ph_done = 1'b1;
    tick;
    ph_fail = 1'b0; ph_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({fail, done, busy} !== 3'b100) begin
      errors++; $display("FAIL fail_pulse got %b expected 100", {fail, done, busy});
    end
    @(negedge clk);
    checks++;
    if (fail !== 1'b0) begin errors++; $display("FAIL fail_width got %b expected 0", fail); end
    checks++;
    if (done_cnt !== 0 || fail_cnt !== 1) begin
      errors++; $display("FAIL fail_counts got done %0d fail %0d expected done 0 fail 1", done_cnt, fail_cnt);
    end
  endtask

  task automatic test_latching;
    clear_mon;
    pulse_go(3'd2, 1'b1);
    drive_beats(30, 1'b0, 1'b0, 20);
    tick;
    go = 1'b1; cfg_start_block = 3'd4; cfg_last_phase = 1'b0;
    tick;
    go = 1'b0;
    drive_beats(140, 1'b0, 1'b0, 100000);
    checks++;
    if (wr_cnt !== 32) begin errors++; $display("FAIL latch_writes got %0d expected 32", wr_cnt); end
    for (int k = 0; k < 32; k++) begin
      checks++;
      if ({wa[k], wd[k]} !== {5'(k), 4'b1010}) begin
        errors++; $display("FAIL latch_word[%0d] got %0d/%b expected %0d/1010", k, wa[k], wd[k], k);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, ph_start_block, ph_last_phase} !== 5'b1_010_1) begin
        errors++; $display("FAIL latch_cfg got %b expected 10101", {busy, ph_start_block, ph_last_phase});
      end
    end
    tick; ph_done = 1'b1;
    tick; ph_done = 1'b0;
    tick;
    checks++;
    if (done_cnt !== 1 || start_cnt !== 1) begin
      errors++; $display("FAIL latch_done got done %0d start %0d expected 1 1", done_cnt, start_cnt);
    end
  endtask

  task automatic test_reset_mid_load;
    clear_mon;
    pulse_go(3'd0, 1'b0);
    drive_beats(20, 1'b0, 1'b0, 10);
    checks++;
    if (acc_cnt !== 10 || wr_cnt !== 2) begin
      errors++; $display("FAIL rml_pre got beats %0d writes %0d expected 10 2", acc_cnt, wr_cnt);
    end
    tick; rst = 1'b1;
    tick; rst = 1'b0;
    for (int c = 0; c < 6; c++) tick;
    @(negedge clk);
    checks++;
    if (wr_cnt !== 2) begin errors++; $display("FAIL rml_no_write got %0d expected 2", wr_cnt); end
    checks++;
    if ({in_ready, busy} !== 2'b00) begin errors++; $display("FAIL rml_idle got %b expected 00", {in_ready, busy}); end
    clear_mon;
    pulse_go(3'd0, 1'b0);
    drive_beats(140, 1'b0, 1'b1, 100000);
    checks++;
    if (wr_cnt !== 32) begin errors++; $display("FAIL rml_reload_writes got %0d expected 32", wr_cnt); end
    checks++;
    if ({wa[0], wd[0]} !== {5'd0, 4'b1111}) begin
      errors++; $display("FAIL rml_first_word got %0d/%b expected 0/1111", wa[0], wd[0]);
    end
    checks++;
    if ({wa[31], wd[31]} !== {5'd31, 4'b1111}) begin
      errors++; $display("FAIL rml_last_word got %0d/%b expected 31/1111", wa[31], wd[31]);
    end
    tick; ph_done = 1'b1;
    tick; ph_done = 1'b0;
    tick;
  endtask

  task automatic test_reset_in_run;
    clear_mon;
    pulse_go(3'd3, 1'b0);
    drive_beats(140, 1'b0, 1'b0, 100000);
    checks++;
    if (start_cnt !== 1) begin errors++; $display("FAIL rir_start got %0d expected 1", start_cnt); end
    tick; rst = 1'b1;
    tick; rst = 1'b0; ph_done = 1'b1;
    tick; ph_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done_cnt !== 0 || fail_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rir_quiet got done %0d fail %0d busy %b expected 0 0 0", done_cnt, fail_cnt, busy);
    end
    checks++;
    if (start_cnt !== 1 || wr_cnt !== 32) begin
      errors++; $display("FAIL rir_no_pulse got start %0d writes %0d expected 1 32", start_cnt, wr_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; cfg_start_block = 3'd0; cfg_last_phase = 1'b0;
    in_valid = 1'b0; in_data = 1'b0; ph_done = 1'b0; ph_fail = 1'b0;
    clear_mon;
    test_reset;
    test_full_load;
    test_throttled;
    test_fail;
    test_latching;
    test_reset_mid_load;
    test_reset_in_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
